// File: rtl/game_pkg.sv
// Shared definitions for the whack-a-mole game session controller.
package game_pkg;

    localparam int TIME_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COUNTDOWN = 2'd1,
        ST_PLAYING   = 2'd2,
        ST_GAME_OVER = 2'd3
    } game_state_t;

endpackage

// File: rtl/sec_prescaler.sv
// Whole-second prescaler: counts 0..CLK_HZ-1 while enabled, otherwise parked at 0.
module sec_prescaler #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic CLOCK_50,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge CLOCK_50) begin
        if (rst || clr || !en)
            r_cnt <= '0;
        else if (r_cnt == LAST)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + CW'(1);
    end

    assign tick = en && (r_cnt == LAST);

endmodule

// File: rtl/game_timer_fsm.sv
// Game session sequencer: IDLE -> COUNTDOWN -> PLAYING -> GAME_OVER, with
// seconds-remaining counter and final/high score latches.
module game_timer_fsm
    import game_pkg::*;
#(
    parameter int CLK_HZ            = 50_000_000,
    parameter int GAME_SECONDS      = 60,
    parameter int COUNTDOWN_SECONDS = 3,
    parameter int SCORE_W           = 12
) (
    input  logic               CLOCK_50,
    input  logic               rst,
    input  logic               start,
    input  logic [SCORE_W-1:0] score,
    output logic               game_on,
    output logic [TIME_W-1:0]  time_left,
    output logic [1:0]         state,
    output logic               score_clr,
    output logic               sec_tick,
    output logic [SCORE_W-1:0] final_score,
    output logic [SCORE_W-1:0] high_score
);

    localparam logic [TIME_W-1:0] GAME_T = TIME_W'(GAME_SECONDS);
    localparam logic [TIME_W-1:0] CD_T   = TIME_W'(COUNTDOWN_SECONDS);

    game_state_t        r_state;
    logic [TIME_W-1:0]  r_time_left;
    logic               r_game_on;
    logic               r_score_clr;
    logic [SCORE_W-1:0] r_final;
    logic [SCORE_W-1:0] r_high;

    logic w_run;
    logic w_tick;
    logic w_last_sec;
    logic w_start_ok;
    logic w_clr;

    assign w_run      = (r_state == ST_COUNTDOWN) || (r_state == ST_PLAYING);
    assign w_last_sec = w_tick && (r_time_left == TIME_W'(1));
    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_GAME_OVER));
    // Every phase entry restarts the prescaler so the first second is full length.
    assign w_clr      = w_start_ok || (w_last_sec && (r_state == ST_COUNTDOWN));

    sec_prescaler #(
        .CLK_HZ(CLK_HZ)
    ) u_presc (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .clr      (w_clr),
        .en       (w_run),
        .tick     (w_tick)
    );

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_time_left <= '0;
            r_game_on   <= 1'b0;
            r_score_clr <= 1'b0;
            r_final     <= '0;
            r_high      <= '0;
        end else begin
            r_score_clr <= 1'b0;
            case (r_state)
                ST_IDLE, ST_GAME_OVER: begin
                    if (start) begin
                        r_state     <= ST_COUNTDOWN;
                        r_time_left <= CD_T;
                        r_score_clr <= 1'b1;
                    end
                end
                ST_COUNTDOWN: begin
                    if (w_last_sec) begin
                        r_state     <= ST_PLAYING;
                        r_time_left <= GAME_T;
                        r_game_on   <= 1'b1;
                    end else if (w_tick) begin
                        r_time_left <= r_time_left - TIME_W'(1);
                    end
                end
                ST_PLAYING: begin
                    if (w_last_sec) begin
                        r_state     <= ST_GAME_OVER;
                        r_time_left <= '0;
                        r_game_on   <= 1'b0;
                        r_final     <= score;
                        if (score > r_high)
                            r_high <= score;
                    end else if (w_tick) begin
                        r_time_left <= r_time_left - TIME_W'(1);
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_time_left <= '0;
                    r_game_on   <= 1'b0;
                end
            endcase
        end
    end

    assign state       = r_state;
    assign time_left   = r_time_left;
    assign game_on     = r_game_on;
    assign score_clr   = r_score_clr;
    assign sec_tick    = w_tick;
    assign final_score = r_final;
    assign high_score  = r_high;

endmodule

// File: tb/tb_game_timer_fsm.sv
// Randomized bench for game_timer_fsm against an elapsed-time reference model.
module tb_game_timer_fsm;

    localparam int HZ = 10;
    localparam int GS = 5;
    localparam int CD = 3;
    localparam int SW = 12;

    logic          CLOCK_50 = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [SW-1:0] score = '0;
    logic          game_on;
    logic [6:0]    time_left;
    logic [1:0]    state;
    logic          score_clr;
    logic          sec_tick;
    logic [SW-1:0] final_score;
    logic [SW-1:0] high_score;

    int n_chk = 0;
    int n_err = 0;

    // Model: phase, cycles elapsed in the phase, latched scores.
    int m_st = 0;
    int m_el = 0;
    int m_final = 0;
    int m_high = 0;
    int m_clr = 0;

    game_timer_fsm #(
        .CLK_HZ(HZ), .GAME_SECONDS(GS), .COUNTDOWN_SECONDS(CD), .SCORE_W(SW)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .rst         (rst),
        .start       (start),
        .score       (score),
        .game_on     (game_on),
        .time_left   (time_left),
        .state       (state),
        .score_clr   (score_clr),
        .sec_tick    (sec_tick),
        .final_score (final_score),
        .high_score  (high_score)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    function automatic int exp_tl();
        if (m_st == 1) return CD - m_el / HZ;
        if (m_st == 2) return GS - m_el / HZ;
        return 0;
    endfunction

    function automatic int exp_tick();
        return ((m_st == 1 || m_st == 2) && (m_el % HZ == HZ - 1)) ? 1 : 0;
    endfunction

    task automatic model_upd(input int s, input int r, input int sc);
        m_clr = 0;
        if (r != 0) begin
            m_st = 0; m_el = 0; m_final = 0; m_high = 0;
        end else begin
            case (m_st)
                0, 3: if (s != 0) begin m_st = 1; m_el = 0; m_clr = 1; end
                1: if (m_el == CD * HZ - 1) begin m_st = 2; m_el = 0; end
                   else m_el++;
                2: if (m_el == GS * HZ - 1) begin
                       m_final = sc;
                       if (sc > m_high) m_high = sc;
                       m_st = 3; m_el = 0;
                   end else m_el++;
                default: m_st = 0;
            endcase
        end
    endtask

    task automatic check_all();
        chk("state", int'(state), m_st);
        chk("time_left", int'(time_left), exp_tl());
        chk("game_on", int'(game_on), (m_st == 2) ? 1 : 0);
        chk("score_clr", int'(score_clr), m_clr);
        chk("sec_tick", int'(sec_tick), exp_tick());
        chk("final_score", int'(final_score), m_final);
        chk("high_score", int'(high_score), m_high);
    endtask

    task automatic cyc(input int s, input int r, input int sc);
        start = 1'(s);
        rst   = 1'(r);
        score = SW'(sc);
        @(posedge CLOCK_50);
        model_upd(s, r, sc);
        @(negedge CLOCK_50);
        check_all();
    endtask

    // Run with constant score until the model reaches target state; counts cycles.
    task automatic run_to(input int target, input int sc, output int n);
        n = 0;
        while (m_st != target && n < 300) begin
            cyc(0, 0, sc);
            n++;
        end
        if (m_st != target) chk("timeout", m_st, target);
    endtask

    task automatic play(input int sc);
        int n;
        cyc(1, 0, sc);
        run_to(3, sc, n);
    endtask

    initial begin
        int n;
        int ph;
        repeat (3) cyc(0, 1, 0);
        for (int i = 0; i < 100; i++) cyc(0, 0, $urandom_range(4095));
        chk("idle_state", int'(state), 0);

        // Start timing and score latching.
        cyc(1, 0, 0);
        chk("cd_entry_tl", int'(time_left), CD);
        chk("cd_entry_clr", int'(score_clr), 1);
        run_to(2, 0, n);
        chk("cd_len", n, 30);
        run_to(3, 0, n);
        chk("play_len", n, 50);

        play(42);
        chk("final42", int'(final_score), 42);
        chk("high42", int'(high_score), 42);
        play(17);
        chk("final17", int'(final_score), 17);
        chk("high_keep", int'(high_score), 42);
        play(42);
        chk("high_eq", int'(high_score), 42);

        // Start pulses during PLAYING are ignored.
        cyc(1, 0, 5);
        n = 0;
        while (m_st != 3 && n < 300) begin
            ph = (m_st == 2) ? m_el : -1;
            cyc((ph == 2 || ph == 20) ? 1 : 0, 0, 5);
            n++;
        end
        chk("end_cycle", n, 80);

        // rst mid-PLAYING with time_left==3.
        cyc(1, 0, 9);
        n = 0;
        while (!(m_st == 2 && exp_tl() == 3) && n < 300) begin cyc(0, 0, 9); n++; end
        chk("tl3_reached", int'(time_left), 3);
        cyc(0, 1, 9);
        chk("rst_state", int'(state), 0);
        chk("rst_high", int'(high_score), 0);
        chk("rst_tl", int'(time_left), 0);

        // start and rst together.
        cyc(1, 1, 0);
        chk("sr_state", int'(state), 0);
        chk("sr_clr", int'(score_clr), 0);

        // Random sessions: random scores, sporadic start/rst.
        for (int g = 0; g < 25; g++) begin
            for (int c = 0; c < 140; c++)
                cyc(($urandom_range(15) == 0) ? 1 : 0,
                    ($urandom_range(399) == 0) ? 1 : 0,
                    $urandom_range(4095));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
